// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_KILL  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage. Owns the PC, keeps one request
// outstanding to instruction memory and hands words to decode over valid/ready.
// Optional build macro FETCH_MISALIGN_TRAP_EN: a PC with nonzero low bits
// raises Fetch_Misaligned and parks the stage in FAULT until a redirect.
//
// state   | meaning
// --------+-----------------------------------------------------------
// REQ     | request PC when the output register is free or draining
// WAIT    | request granted, waiting for read data
// KILL    | request granted but flushed; drop its read data
// FAULT   | misaligned PC trapped; idle until redirect
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] Next_PC,
  input  logic        Redirect,
  output logic [31:0] PC_Plus4,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Gnt,
  input  logic        Imem_Rvalid,
  input  logic [31:0] Imem_Rdata,
  output logic        IF_Valid,
  output logic [31:0] IF_Instr,
  output logic [31:0] IF_PC,
  input  logic        ID_Ready,
  output logic        Fetch_Misaligned
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  req_pc_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;
  logic         if_valid_q;
  logic         misaligned_pc;
  logic         req;
  logic         grant;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;

  assign misaligned_pc    = (pc_q[1:0] != 2'b00);
  assign Imem_Addr        = pc_q;
  assign Fetch_Misaligned = misaligned_q;

  // Fault flag: raised on the REQ->FAULT transition, held until a redirect.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      misaligned_q <= 1'b0;
    end else if (Redirect) begin
      misaligned_q <= 1'b0;
    end else if (state_q == ST_REQ && misaligned_pc) begin
      misaligned_q <= 1'b1;
    end
  end
`else
  assign misaligned_pc    = 1'b0;
  assign Imem_Addr        = {pc_q[31:2], 2'b00};
  assign Fetch_Misaligned = 1'b0;
`endif

  // Request only when the output register can take the response; gated in reset.
  assign req      = Reset_n && (state_q == ST_REQ) && !misaligned_pc &&
                    (!if_valid_q || ID_Ready);
  assign grant    = req && Imem_Gnt;
  assign Imem_Req = req;
  assign PC_Plus4 = pc_q + 32'd4;
  assign IF_Valid = if_valid_q;
  assign IF_Instr = if_instr_q;
  assign IF_PC    = if_pc_q;

  // Fetch FSM, PC, request address and output register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else begin
      if (if_valid_q && ID_Ready) begin
        if_valid_q <= 1'b0;
      end
      if (Redirect) begin
        pc_q       <= Next_PC;
        if_valid_q <= 1'b0;
        if (grant) begin
          req_pc_q <= pc_q;
        end
        case (state_q)
          ST_REQ:           state_q <= grant ? ST_KILL : ST_REQ;
          // A response arriving with the redirect is dropped right away;
          // otherwise keep waiting for it in KILL.
          ST_WAIT, ST_KILL: state_q <= Imem_Rvalid ? ST_REQ : ST_KILL;
          default:          state_q <= ST_REQ;
        endcase
      end else begin
        case (state_q)
          ST_REQ: begin
            if (misaligned_pc) begin
              state_q <= ST_FAULT;
            end else if (grant) begin
              req_pc_q <= pc_q;
              pc_q     <= Next_PC;
              state_q  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (Imem_Rvalid) begin
              if_instr_q <= Imem_Rdata;
              if_pc_q    <= req_pc_q;
              if_valid_q <= 1'b1;
              state_q    <= ST_REQ;
            end
          end
          ST_KILL: begin
            if (Imem_Rvalid) begin
              state_q <= ST_REQ;
            end
          end
          ST_FAULT: state_q <= ST_FAULT;
          default:  state_q <= ST_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench for fetch_pc_unit with an instruction scoreboard.
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] Next_PC;
  logic        Redirect = 1'b0;
  logic [31:0] PC_Plus4;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Gnt = 1'b0;
  logic        Imem_Rvalid = 1'b0;
  logic [31:0] Imem_Rdata = 32'h0;
  logic        IF_Valid;
  logic [31:0] IF_Instr;
  logic [31:0] IF_PC;
  logic        ID_Ready = 1'b1;
  logic        Fetch_Misaligned;
  logic [31:0] redir_tgt = 32'h0;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] sb_e;

  // External next-PC mux: sequential unless redirected.
  assign Next_PC = Redirect ? redir_tgt : PC_Plus4;

  always #5 Clk = ~Clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_0100)) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .Next_PC          (Next_PC),
    .Redirect         (Redirect),
    .PC_Plus4         (PC_Plus4),
    .Imem_Req         (Imem_Req),
    .Imem_Addr        (Imem_Addr),
    .Imem_Gnt         (Imem_Gnt),
    .Imem_Rvalid      (Imem_Rvalid),
    .Imem_Rdata       (Imem_Rdata),
    .IF_Valid         (IF_Valid),
    .IF_Instr         (IF_Instr),
    .IF_PC            (IF_PC),
    .ID_Ready         (ID_Ready),
    .Fetch_Misaligned (Fetch_Misaligned)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  // One granted fetch with one-cycle read latency; the response is scored.
  task automatic fetch(input logic [31:0] addr, input int exp_valid);
    Imem_Gnt = 1'b1; Imem_Rvalid = 1'b0; Redirect = 1'b0;
    @(negedge Clk);
    if (exp_valid >= 0) chk("if_valid_latency", {31'h0, IF_Valid}, exp_valid);
    chk("req_issued", {31'h0, Imem_Req}, 32'd1);
    chk("req_addr", Imem_Addr, addr);
    next_cycle();
    Imem_Gnt = 1'b0; Imem_Rvalid = 1'b1; Imem_Rdata = word_at(addr);
    sb.push_back({addr, word_at(addr)});
    @(negedge Clk);
    chk("req_low_in_wait", {31'h0, Imem_Req}, 32'd0);
    chk("valid_low_in_wait", {31'h0, IF_Valid}, 32'd0);
    next_cycle();
    Imem_Rvalid = 1'b0;
  endtask

  // Scoreboard: every accepted instruction must match the oldest expected one.
  always @(negedge Clk) begin
    if (Reset_n && IF_Valid === 1'b1 && ID_Ready) begin
      chk("unexpected_instr", {31'h0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        sb_e = sb.pop_front();
        chk("if_pc", IF_PC, sb_e[63:32]);
        chk("if_instr", IF_Instr, sb_e[31:0]);
      end
    end
  end

  initial begin
    // Reset values
    @(negedge Clk);
    chk("rst_req", {31'h0, Imem_Req}, 32'd0);
    chk("rst_valid", {31'h0, IF_Valid}, 32'd0);
    chk("rst_instr", IF_Instr, NOP_INSTR);
    chk("rst_if_pc", IF_PC, 32'h100);
    chk("rst_addr", Imem_Addr, 32'h100);
    chk("rst_plus4", PC_Plus4, 32'h104);
    chk("rst_misaligned", {31'h0, Fetch_Misaligned}, 32'd0);
    next_cycle();
    Reset_n = 1'b1;

    // Back-to-back fetches: IF_Valid on cycles 2, 4, 6
    fetch(32'h100, 0);
    fetch(32'h104, 1);
    fetch(32'h108, 1);

    // Decode stall holds the word and suppresses requests
    ID_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("stall_valid", {31'h0, IF_Valid}, 32'd1);
      chk("stall_req", {31'h0, Imem_Req}, 32'd0);
      chk("stall_instr", IF_Instr, word_at(32'h108));
      chk("stall_pc", IF_PC, 32'h108);
      next_cycle();
    end
    ID_Ready = 1'b1;
    fetch(32'h10C, 1);

    // Redirect while waiting: the in-flight word is dropped
    Imem_Gnt = 1'b1;
    @(negedge Clk);
    chk("wait_redir_req", {31'h0, Imem_Req}, 32'd1);
    chk("wait_redir_addr", Imem_Addr, 32'h110);
    next_cycle();
    Imem_Gnt = 1'b0; Redirect = 1'b1; redir_tgt = 32'h200;
    @(negedge Clk);
    chk("wait_redir_req_low", {31'h0, Imem_Req}, 32'd0);
    next_cycle();
    Redirect = 1'b0; Imem_Rvalid = 1'b1; Imem_Rdata = 32'hDEAD_BEEF;
    @(negedge Clk);
    chk("kill_req_low", {31'h0, Imem_Req}, 32'd0);
    chk("kill_valid_low", {31'h0, IF_Valid}, 32'd0);
    next_cycle();
    Imem_Rvalid = 1'b0;
    fetch(32'h200, 0);
    fetch(32'h204, 1);

    // Redirect coincident with a grant: that response is killed
    Imem_Gnt = 1'b1; Redirect = 1'b1; redir_tgt = 32'h280;
    @(negedge Clk);
    chk("req_redir_req", {31'h0, Imem_Req}, 32'd1);
    chk("req_redir_addr", Imem_Addr, 32'h208);
    next_cycle();
    Imem_Gnt = 1'b0; Redirect = 1'b0; Imem_Rvalid = 1'b1; Imem_Rdata = word_at(32'h208);
    @(negedge Clk);
    chk("req_redir_kill_req", {31'h0, Imem_Req}, 32'd0);
    chk("req_redir_kill_valid", {31'h0, IF_Valid}, 32'd0);
    next_cycle();
    Imem_Rvalid = 1'b0;
    fetch(32'h280, 0);
    fetch(32'h284, 1);

    // No grant for 10 cycles: request and address stay put
    Imem_Gnt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("hold_req", {31'h0, Imem_Req}, 32'd1);
      chk("hold_addr", Imem_Addr, 32'h288);
      next_cycle();
    end

    // Reset in WAIT: outputs return to reset values immediately
    Imem_Gnt = 1'b1;
    @(negedge Clk);
    chk("pre_rst_if_pc", IF_PC, 32'h284);
    next_cycle();
    Imem_Gnt = 1'b0;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, Imem_Req}, 32'd0);
    chk("mid_rst_valid", {31'h0, IF_Valid}, 32'd0);
    chk("mid_rst_instr", IF_Instr, NOP_INSTR);
    chk("mid_rst_if_pc", IF_PC, 32'h100);
    chk("mid_rst_addr", Imem_Addr, 32'h100);
    chk("mid_rst_plus4", PC_Plus4, 32'h104);
    next_cycle();
    next_cycle();
    Reset_n = 1'b1;
    fetch(32'h100, 0);
    fetch(32'h104, 1);

    // Misaligned redirect target
    Redirect = 1'b1; redir_tgt = 32'h202;
    @(negedge Clk);
    next_cycle();
    Redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    @(negedge Clk);
    chk("misal_no_req", {31'h0, Imem_Req}, 32'd0);
    chk("misal_flag_pre", {31'h0, Fetch_Misaligned}, 32'd0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("fault_flag", {31'h0, Fetch_Misaligned}, 32'd1);
      chk("fault_no_req", {31'h0, Imem_Req}, 32'd0);
      next_cycle();
    end
    Redirect = 1'b1; redir_tgt = 32'h300;
    @(negedge Clk);
    chk("fault_flag_redir", {31'h0, Fetch_Misaligned}, 32'd1);
    next_cycle();
    Redirect = 1'b0;
`else
    @(negedge Clk);
    chk("misal_req", {31'h0, Imem_Req}, 32'd1);
    chk("misal_addr_aligned", Imem_Addr, 32'h200);
    chk("misal_flag_tied", {31'h0, Fetch_Misaligned}, 32'd0);
    next_cycle();
    Redirect = 1'b1; redir_tgt = 32'h300;
    @(negedge Clk);
    next_cycle();
    Redirect = 1'b0;
`endif
    @(negedge Clk);
    chk("resume_flag", {31'h0, Fetch_Misaligned}, 32'd0);
    chk("resume_req", {31'h0, Imem_Req}, 32'd1);
    chk("resume_addr", Imem_Addr, 32'h300);
    next_cycle();
    fetch(32'h300, 0);
    fetch(32'h304, 1);
    @(negedge Clk);
    next_cycle();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
